// File: rtl/inst_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : inst_dispatcher
// Purpose  : Accepts an instruction word from the host interfacer, checks its
//            opcode, issues a one-cycle start to the coprocessor core, waits
//            for completion (with watchdog), and returns a level done to the
//            interfacer. Tracks per-instruction latency and a completion count.
// Revision : 1.0  initial release
// ============================================================================
module inst_dispatcher #(
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000,
   parameter logic [7:0]  MAX_OPCODE     = 8'd31
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] inst_in,
   output logic        done_out,
   output logic        core_start,
   output logic [7:0]  core_opcode,
   output logic        core_mod_sel,
   output logic [3:0]  core_rdM0,
   output logic [3:0]  core_rdM1,
   output logic [3:0]  core_wtM0,
   output logic [3:0]  core_wtM1,
   input  logic        core_done,
   input  logic        err_clr,
   output logic        err_timeout,
   output logic        err_opcode,
   output logic [31:0] last_latency,
   output logic [31:0] inst_count
);

   // A zero limit turns the watchdog off entirely.
   localparam logic        c_WD_EN   = (TIMEOUT_CYCLES != 32'd0);
   localparam logic [31:0] c_CNT_MAX = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_BUSY  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;

   // Latched instruction fields, held for the whole ISSUE/BUSY window.
   logic [7:0]  r_opcode;
   logic        r_mod_sel;
   logic [3:0]  r_rdM0;
   logic [3:0]  r_rdM1;
   logic [3:0]  r_wtM0;
   logic [3:0]  r_wtM1;

   logic [31:0] r_lat_cnt;
   logic        r_core_start;
   logic        r_done_out;
   logic        r_err_timeout;
   logic        r_err_opcode;
   logic [31:0] r_last_latency;
   logic [31:0] r_inst_count;

   logic        w_inst_valid;
   logic        w_op_legal;
   logic        w_timeout_hit;
   logic        w_latch;
   logic        w_set_err_op;
   logic        w_complete;
   logic        w_expire;
   logic        w_fields_en;
   logic        w_unused_bits;

   // Instruction decode: nonzero word means a request, opcode must be 1..MAX.
   always_comb begin
      w_inst_valid  = (inst_in != 32'd0);
      w_op_legal    = (inst_in[7:0] != 8'd0) && (inst_in[7:0] <= MAX_OPCODE);
      w_timeout_hit = c_WD_EN && (r_lat_cnt == TIMEOUT_CYCLES);
      w_unused_bits = ^inst_in[15:9];
   end

   // Next-state logic and single-cycle event strobes.
   always_comb begin
      w_state_nxt  = r_state;
      w_latch      = 1'b0;
      w_set_err_op = 1'b0;
      w_complete   = 1'b0;
      w_expire     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_inst_valid) begin
               if (w_op_legal) begin
                  w_latch     = 1'b1;
                  w_state_nxt = S_ISSUE;
               end else begin
                  w_set_err_op = 1'b1;
                  w_state_nxt  = S_DONE;
               end
            end
         end
         S_ISSUE: begin
            w_state_nxt = S_BUSY;
         end
         S_BUSY: begin
            // A completion in the same cycle as the watchdog limit is honoured.
            if (core_done) begin
               w_complete  = 1'b1;
               w_state_nxt = S_DONE;
            end else if (w_timeout_hit) begin
               w_expire    = 1'b1;
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            // The interfacer must return to idle before a new word is taken.
            if (!w_inst_valid) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Capture instruction fields when a legal word is accepted.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_opcode  <= 8'd0;
         r_mod_sel <= 1'b0;
         r_rdM0    <= 4'd0;
         r_rdM1    <= 4'd0;
         r_wtM0    <= 4'd0;
         r_wtM1    <= 4'd0;
      end else if (w_latch) begin
         r_opcode  <= inst_in[7:0];
         r_mod_sel <= inst_in[8];
         r_rdM0    <= inst_in[19:16];
         r_rdM1    <= inst_in[23:20];
         r_wtM0    <= inst_in[27:24];
         r_wtM1    <= inst_in[31:28];
      end
   end

   // Latency counter: zero during ISSUE, so it reads 1 on the first BUSY cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_lat_cnt <= 32'd0;
      end else if (w_latch) begin
         r_lat_cnt <= 32'd0;
      end else if ((r_state == S_ISSUE || r_state == S_BUSY) && r_lat_cnt != c_CNT_MAX) begin
         r_lat_cnt <= r_lat_cnt + 32'd1;
      end
   end

   // Statistics: latency of the last instruction and saturating completion count.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_last_latency <= 32'd0;
         r_inst_count   <= 32'd0;
      end else if (w_complete) begin
         r_last_latency <= r_lat_cnt;
         if (r_inst_count != c_CNT_MAX) begin
            r_inst_count <= r_inst_count + 32'd1;
         end
      end else if (w_expire) begin
         r_last_latency <= TIMEOUT_CYCLES;
      end
   end

   // Sticky error flags; a new error outranks a clear in the same cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_err_timeout <= 1'b0;
         r_err_opcode  <= 1'b0;
      end else begin
         if (w_expire) begin
            r_err_timeout <= 1'b1;
         end else if (err_clr) begin
            r_err_timeout <= 1'b0;
         end
         if (w_set_err_op) begin
            r_err_opcode <= 1'b1;
         end else if (err_clr) begin
            r_err_opcode <= 1'b0;
         end
      end
   end

   // Registered handshake outputs, decoded from the state being entered.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_core_start <= 1'b0;
         r_done_out   <= 1'b0;
      end else begin
         r_core_start <= (w_state_nxt == S_ISSUE);
         r_done_out   <= (w_state_nxt == S_DONE);
      end
   end

   // Core field outputs: latched values only while the core owns them.
   always_comb begin
      w_fields_en  = (r_state == S_ISSUE) || (r_state == S_BUSY);
      core_opcode  = 8'd0;
      core_mod_sel = 1'b0;
      core_rdM0    = 4'd0;
      core_rdM1    = 4'd0;
      core_wtM0    = 4'd0;
      core_wtM1    = 4'd0;
      if (w_fields_en) begin
         core_opcode  = r_opcode;
         core_mod_sel = r_mod_sel;
         core_rdM0    = r_rdM0;
         core_rdM1    = r_rdM1;
         core_wtM0    = r_wtM0;
         core_wtM1    = r_wtM1;
      end
   end

   assign core_start   = r_core_start;
   assign done_out     = r_done_out;
   assign err_timeout  = r_err_timeout;
   assign err_opcode   = r_err_opcode;
   assign last_latency = r_last_latency;
   assign inst_count   = r_inst_count;

endmodule
`default_nettype wire

// File: tb/tb_inst_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_dispatcher
// Purpose  : Directed, self-checking bench for inst_dispatcher. A transaction-
//            level model predicts every output each cycle; literal checks pin
//            the key scenario results.
// Revision : 1.0  initial release
// ============================================================================
module tb_inst_dispatcher;

   localparam logic [31:0] c_TMO = 32'd16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] inst_in;
   logic        done_out;
   logic        core_start;
   logic [7:0]  core_opcode;
   logic        core_mod_sel;
   logic [3:0]  core_rdM0, core_rdM1, core_wtM0, core_wtM1;
   logic        core_done;
   logic        err_clr;
   logic        err_timeout;
   logic        err_opcode;
   logic [31:0] last_latency;
   logic [31:0] inst_count;

   int n_vec = 0;
   int n_bad = 0;
   int n_starts = 0;

   inst_dispatcher #(
      .TIMEOUT_CYCLES (c_TMO),
      .MAX_OPCODE     (8'd31)
   ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .inst_in      (inst_in),
      .done_out     (done_out),
      .core_start   (core_start),
      .core_opcode  (core_opcode),
      .core_mod_sel (core_mod_sel),
      .core_rdM0    (core_rdM0),
      .core_rdM1    (core_rdM1),
      .core_wtM0    (core_wtM0),
      .core_wtM1    (core_wtM1),
      .core_done    (core_done),
      .err_clr      (err_clr),
      .err_timeout  (err_timeout),
      .err_opcode   (err_opcode),
      .last_latency (last_latency),
      .inst_count   (inst_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // m_age: 0 = nothing in flight, 1 = start cycle, n>1 = BUSY cycle n-1.
   // m_held: done shown to the interfacer until it returns inst_in to 0.
   bit          m_valid = 0;
   bit          m_held;
   int          m_age;
   logic [31:0] m_word;
   logic [31:0] m_lat;
   logic [31:0] m_cnt;
   bit          m_eto;
   bit          m_eop;
   bit          m_set_to;
   bit          m_set_op;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_valid = 1; m_held = 0; m_age = 0; m_word = 0;
         m_lat = 0; m_cnt = 0; m_eto = 0; m_eop = 0;
      end else begin
         m_set_to = 0;
         m_set_op = 0;
         if (m_held) begin
            if (inst_in == 32'd0) m_held = 0;
         end else if (m_age == 0) begin
            if (inst_in != 32'd0) begin
               if (inst_in[7:0] >= 8'd1 && inst_in[7:0] <= 8'd31) begin
                  m_word = inst_in;
                  m_age  = 1;
               end else begin
                  m_set_op = 1;
                  m_held   = 1;
               end
            end
         end else if (m_age == 1) begin
            m_age = 2;
         end else begin
            if (core_done) begin
               m_lat = m_age - 1;
               if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
               m_age = 0; m_held = 1;
            end else if (m_age - 1 == int'(c_TMO)) begin
               m_lat = c_TMO;
               m_set_to = 1;
               m_age = 0; m_held = 1;
            end else begin
               m_age = m_age + 1;
            end
         end
         if (m_set_to) m_eto = 1; else if (err_clr) m_eto = 0;
         if (m_set_op) m_eop = 1; else if (err_clr) m_eop = 0;
      end
   end

   // Compare every cycle, away from the active edge.
   always @(negedge clk) begin
      if (core_start) n_starts++;
      if (m_valid) begin
         chk("done_out",     {31'd0, done_out},     {31'd0, m_held});
         chk("core_start",   {31'd0, core_start},   {31'd0, m_age == 1});
         chk("core_opcode",  {24'd0, core_opcode},  (m_age > 0) ? {24'd0, m_word[7:0]}   : 32'd0);
         chk("core_mod_sel", {31'd0, core_mod_sel}, (m_age > 0) ? {31'd0, m_word[8]}     : 32'd0);
         chk("core_rdM0",    {28'd0, core_rdM0},    (m_age > 0) ? {28'd0, m_word[19:16]} : 32'd0);
         chk("core_rdM1",    {28'd0, core_rdM1},    (m_age > 0) ? {28'd0, m_word[23:20]} : 32'd0);
         chk("core_wtM0",    {28'd0, core_wtM0},    (m_age > 0) ? {28'd0, m_word[27:24]} : 32'd0);
         chk("core_wtM1",    {28'd0, core_wtM1},    (m_age > 0) ? {28'd0, m_word[31:28]} : 32'd0);
         chk("err_timeout",  {31'd0, err_timeout},  {31'd0, m_eto});
         chk("err_opcode",   {31'd0, err_opcode},   {31'd0, m_eop});
         chk("last_latency", last_latency, m_lat);
         chk("inst_count",   inst_count,   m_cnt);
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Present a word; returns in the cycle after it is sampled.
   task automatic issue(input logic [31:0] w);
      inst_in = w;
      cyc(1);
   endtask

   // Run BUSY until done_out; pulse core_done on BUSY cycle done_at (0 = never).
   task automatic finish(input int done_at, input logic [31:0] mid);
      int k;
      k = 0;
      while (!done_out && k < 40) begin
         cyc(1);
         k++;
         if (done_out) break;
         if (mid != 32'd0 && k == 2) inst_in = mid;
         core_done = (k == done_at);
      end
      core_done = 1'b0;
      if (!done_out) begin
         n_vec++;
         n_bad++;
         $display("FAIL done_wait: done_out never rose within 40 cycles");
      end
   endtask

   task automatic release_inst();
      inst_in = 32'd0;
      cyc(2);
   endtask

   int s0;

   initial begin
      rst_n = 1'b0; inst_in = 32'd0; core_done = 1'b0; err_clr = 1'b0;
      cyc(2);
      rst_n = 1'b1;
      chk("rst_done_out", {31'd0, done_out}, 32'd0);
      chk("rst_inst_count", inst_count, 32'd0);
      chk("rst_errors", {30'd0, err_timeout, err_opcode}, 32'd0);
      cyc(1);

      // Legal instruction, completion on BUSY cycle 10.
      issue(32'h2100_0105);
      chk("lg_start",  {31'd0, core_start}, 32'd1);
      chk("lg_opcode", {24'd0, core_opcode}, 32'd5);
      chk("lg_mod",    {31'd0, core_mod_sel}, 32'd1);
      chk("lg_rdM0",   {28'd0, core_rdM0}, 32'd0);
      chk("lg_wtM0",   {28'd0, core_wtM0}, 32'd1);
      chk("lg_wtM1",   {28'd0, core_wtM1}, 32'd2);
      finish(10, 32'd0);
      chk("lg_done", {31'd0, done_out}, 32'd1);
      chk("lg_latency", last_latency, 32'd10);
      chk("lg_count", inst_count, 32'd1);
      inst_in = 32'd0;
      cyc(1);
      chk("lg_done_drop", {31'd0, done_out}, 32'd0);
      cyc(1);

      // Illegal opcode 64.
      issue(32'h0000_0040);
      chk("il_done", {31'd0, done_out}, 32'd1);
      chk("il_nostart", {31'd0, core_start}, 32'd0);
      chk("il_err", {31'd0, err_opcode}, 32'd1);
      finish(0, 32'd0);
      chk("il_count", inst_count, 32'd1);
      release_inst();

      // Watchdog expiry after 16 BUSY cycles.
      issue(32'h0000_0103);
      finish(0, 32'd0);
      chk("wd_err", {31'd0, err_timeout}, 32'd1);
      chk("wd_latency", last_latency, 32'd16);
      chk("wd_count", inst_count, 32'd1);
      release_inst();
      err_clr = 1'b1;
      cyc(1);
      err_clr = 1'b0;
      chk("clr_timeout", {31'd0, err_timeout}, 32'd0);
      chk("clr_opcode", {31'd0, err_opcode}, 32'd0);

      // core_done on the very cycle the watchdog would fire.
      issue(32'h0000_0107);
      finish(16, 32'd0);
      chk("sim_err", {31'd0, err_timeout}, 32'd0);
      chk("sim_latency", last_latency, 32'd16);
      chk("sim_count", inst_count, 32'd2);
      release_inst();

      // Illegal opcode 0 captured together with err_clr.
      err_clr = 1'b1;
      issue(32'h0000_0100);
      err_clr = 1'b0;
      chk("setclr_err", {31'd0, err_opcode}, 32'd1);
      finish(0, 32'd0);
      release_inst();

      // Reset during BUSY cycle 5, then a stale core_done.
      issue(32'h1234_0009);
      cyc(5);
      rst_n = 1'b0;
      inst_in = 32'd0;
      cyc(1);
      rst_n = 1'b1;
      chk("mr_count", inst_count, 32'd0);
      chk("mr_latency", last_latency, 32'd0);
      chk("mr_opcode", {24'd0, core_opcode}, 32'd0);
      chk("mr_flags", {28'd0, done_out, core_start, err_timeout, err_opcode}, 32'd0);
      core_done = 1'b1;
      cyc(1);
      core_done = 1'b0;
      cyc(1);
      chk("stale_count", inst_count, 32'd0);
      chk("stale_done", {31'd0, done_out}, 32'd0);

      // Three back-to-back instructions with inst_in changing mid-BUSY.
      s0 = n_starts;
      for (int i = 0; i < 3; i++) begin
         issue(32'h5A30_0101 + (i << 24) + i);
         finish(5 + i, 32'hFFFF_FFFF);
         release_inst();
      end
      chk("b2b_count", inst_count, 32'd3);
      chk("b2b_starts", n_starts - s0, 32'd3);
      chk("b2b_latency", last_latency, 32'd7);

      cyc(2);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
